lock_sequencer: RTL

Sequencing controller for the electronic combination lock.
- Consumes the debounced single-cycle button pulses: bit-0, bit-1, clear and program.
- Collects a fixed-length code, compares it against a programmable stored code, and drives the unlock indicator.
- Enforces a failed-attempt lockout and supports re-programming the code while open.
- Exports a 3-bit state code for the seven-segment decoder.

---
 rtl/lock_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: sequencing controller for the electronic combination lock.
//   Collects a CODE_LEN-bit code from debounced single-cycle pulses and
//   compares it with a programmable stored code. It opens the lock for
//   OPEN_CYCLES cycles, or enters a lockout of LOCK_CYCLES cycles after
//   MAX_FAIL consecutive wrong codes. The code can be reprogrammed while open.
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset
//   b0, b1     pulse: enter bit 0 / bit 1 (both together = no event)
//   clr        pulse: abort current entry / relock
//   prog       pulse: request code change (only honoured while open)
//   unlock     1 = lock open
//   alarm      1 = lockout active
//   entry_cnt  bits entered so far in ENTRY/PROG, else 0
//   fail_cnt   consecutive failed attempts (saturates at MAX_FAIL)
//   state      IDLE=0, ENTRY=1, OPEN=2, PROG=3, LOCKOUT=4
module lock_sequencer #(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] CODE_INIT   = 4'b1011,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  OPEN_CYCLES = 50000000,
  parameter int                  LOCK_CYCLES = 250000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b0,
  input  logic       b1,
  input  logic       clr,
  input  logic       prog,
  output logic       unlock,
  output logic       alarm,
  output logic [2:0] entry_cnt,
  output logic [1:0] fail_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_OPEN    = 3'd2;
  localparam logic [2:0] S_PROG    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [2:0]          state_q, state_d;
  logic                unlock_q, unlock_d;
  logic                alarm_q, alarm_d;
  logic [2:0]          entry_cnt_q, entry_cnt_d;
  logic [1:0]          fail_cnt_q, fail_cnt_d;
  logic [CODE_LEN-1:0] shreg_q, shreg_d;
  logic [CODE_LEN-1:0] code_q, code_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic                bit_evt;
  logic                last_bit;
  logic [CODE_LEN:0]   shift_full;
  logic [CODE_LEN-1:0] shifted;
  logic [2:0]          fail_inc;
  logic                unused_msb;

  // A clr or prog pulse in the same cycle pre-empts a bit event.
  assign bit_evt    = (b0 ^ b1) && !clr && !prog;
  // On a valid bit event b1 is exactly the entered bit value.
  assign shift_full = {shreg_q, b1};
  assign shifted    = shift_full[CODE_LEN-1:0];
  assign unused_msb = shift_full[CODE_LEN];
  assign last_bit   = (entry_cnt_q == 3'(CODE_LEN - 1));
  assign fail_inc   = {1'b0, fail_cnt_q} + 3'd1;

  always_comb begin
    state_d     = state_q;
    unlock_d    = unlock_q;
    alarm_d     = alarm_q;
    entry_cnt_d = entry_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    shreg_d     = shreg_q;
    code_d      = code_q;
    timer_d     = timer_q;

    case (state_q)
      // IDLE and ENTRY share the collect/compare path; entry_cnt is 0 in IDLE,
      // so a one-bit code compares on the very first pulse.
      S_IDLE, S_ENTRY: begin
        if (state_q == S_ENTRY && clr) begin
          state_d     = S_IDLE;
          entry_cnt_d = 3'd0;
          shreg_d     = '0;
        end else if (bit_evt) begin
          if (last_bit) begin
            entry_cnt_d = 3'd0;
            shreg_d     = '0;
            if (shifted == code_q) begin
              state_d    = S_OPEN;
              unlock_d   = 1'b1;
              fail_cnt_d = 2'd0;
              timer_d    = TW'(OPEN_CYCLES - 1);
            end else if (fail_inc >= 3'(MAX_FAIL)) begin
              state_d    = S_LOCKOUT;
              alarm_d    = 1'b1;
              fail_cnt_d = 2'(MAX_FAIL);
              timer_d    = TW'(LOCK_CYCLES - 1);
            end else begin
              state_d    = S_IDLE;
              fail_cnt_d = fail_inc[1:0];
            end
          end else begin
            state_d     = S_ENTRY;
            shreg_d     = shifted;
            entry_cnt_d = entry_cnt_q + 3'd1;
          end
        end
      end

      S_OPEN: begin
        if (clr) begin
          state_d  = S_IDLE;
          unlock_d = 1'b0;
        end else if (prog) begin
          // Timer holds its value for the whole programming session.
          state_d     = S_PROG;
          entry_cnt_d = 3'd0;
          shreg_d     = '0;
        end else if (timer_q == '0) begin
          state_d  = S_IDLE;
          unlock_d = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_PROG: begin
        if (clr) begin
          state_d     = S_IDLE;
          unlock_d    = 1'b0;
          entry_cnt_d = 3'd0;
          shreg_d     = '0;
        end else if (bit_evt) begin
          if (last_bit) begin
            code_d      = shifted;
            state_d     = S_IDLE;
            unlock_d    = 1'b0;
            entry_cnt_d = 3'd0;
            shreg_d     = '0;
          end else begin
            shreg_d     = shifted;
            entry_cnt_d = entry_cnt_q + 3'd1;
          end
        end
      end

      S_LOCKOUT: begin
        // Every input, clr included, is ignored until the timer expires.
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          alarm_d    = 1'b0;
          fail_cnt_d = 2'd0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        unlock_d    = 1'b0;
        alarm_d     = 1'b0;
        entry_cnt_d = 3'd0;
        shreg_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      entry_cnt_q <= 3'd0;
      fail_cnt_q  <= 2'd0;
      shreg_q     <= '0;
      code_q      <= CODE_INIT;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      unlock_q    <= unlock_d;
      alarm_q     <= alarm_d;
      entry_cnt_q <= entry_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      shreg_q     <= shreg_d;
      code_q      <= code_d;
      timer_q     <= timer_d;
    end
  end

  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign entry_cnt = entry_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign state     = state_q;

endmodule
